// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the two client ports and the SDRAM controller command port.
// The arbiter connects through the slave modport; the clients and the
// controller model (or the surrounding logic) use the master modport.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    // Client port 0
    logic              p0_req;
    logic              p0_wr;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [1:0]        p0_be;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    // Client port 1
    logic              p1_req;
    logic              p1_wr;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [1:0]        p1_be;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    // Controller command port
    logic              ctl_req;
    logic              ctl_wr;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_wdata;
    logic [1:0]        ctl_be;
    logic              ctl_ack;
    logic              ctl_done;
    logic [DATA_W-1:0] ctl_rdata;
    logic              ctl_refresh;
    logic              ctl_refresh_done;

    modport slave (
        input  p0_req, p0_wr, p0_addr, p0_wdata, p0_be,
        output p0_ack, p0_rdata,
        input  p1_req, p1_wr, p1_addr, p1_wdata, p1_be,
        output p1_ack, p1_rdata,
        output ctl_req, ctl_wr, ctl_addr, ctl_wdata, ctl_be, ctl_refresh,
        input  ctl_ack, ctl_done, ctl_rdata, ctl_refresh_done
    );

    modport master (
        output p0_req, p0_wr, p0_addr, p0_wdata, p0_be,
        input  p0_ack, p0_rdata,
        output p1_req, p1_wr, p1_addr, p1_wdata, p1_be,
        input  p1_ack, p1_rdata,
        input  ctl_req, ctl_wr, ctl_addr, ctl_wdata, ctl_be, ctl_refresh,
        output ctl_ack, ctl_done, ctl_rdata, ctl_refresh_done
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between two clients and an
// internal refresh scheduler. Clients are served round-robin; refresh is
// taken when nobody is asking, or ahead of clients once it becomes urgent.
// A granted client transaction always runs to completion before anything else.
module sdram_port_arbiter #(
    parameter int ADDR_W           = 24,
    parameter int DATA_W           = 16,
    parameter int REFRESH_INTERVAL = 780,
    parameter int MAX_PENDING      = 3,
    parameter int URGENT_PENDING   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sdram_port_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 refresh_overflow
);

    localparam int CNT_W  = $clog2(REFRESH_INTERVAL + 1);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    localparam logic [CNT_W-1:0]  CNT_RELOAD  = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [PEND_W-1:0] PEND_MAX    = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_URGENT = PEND_W'(URGENT_PENDING);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        REFRESH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic               ctl_req_q, ctl_req_d;
    logic               ctl_wr_q, ctl_wr_d;
    logic [ADDR_W-1:0]  ctl_addr_q, ctl_addr_d;
    logic [DATA_W-1:0]  ctl_wdata_q, ctl_wdata_d;
    logic [1:0]         ctl_be_q, ctl_be_d;
    logic               ctl_refresh_q, ctl_refresh_d;
    logic               p0_ack_q, p0_ack_d;
    logic               p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0]  p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]  p1_rdata_q, p1_rdata_d;

    logic refresh_tick;
    logic refresh_grant;
    logic grant_en;
    logic grant_sel;
    logic complete;
    logic p0_elig;
    logic p1_elig;

    // A client still holding req in its own ack cycle is not a new request.
    assign p0_elig = bus.p0_req && !p0_ack_q;
    assign p1_elig = bus.p1_req && !p1_ack_q;

    // Free-running refresh interval timer, independent of the FSM state.
    always_comb begin
        refresh_tick = (cnt_q == '0);
        cnt_d        = refresh_tick ? CNT_RELOAD : cnt_q - 1'b1;
    end

    // Pending-refresh counter: ticks add, refresh grants remove, saturating.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q || (refresh_tick && (pend_q == PEND_MAX));
        if (refresh_tick && !refresh_grant) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!refresh_tick && refresh_grant) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Arbitration FSM next state and registered command/ack outputs.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        ctl_req_d     = ctl_req_q;
        ctl_wr_d      = ctl_wr_q;
        ctl_addr_d    = ctl_addr_q;
        ctl_wdata_d   = ctl_wdata_q;
        ctl_be_d      = ctl_be_q;
        ctl_refresh_d = ctl_refresh_q;
        p0_ack_d      = 1'b0;
        p1_ack_d      = 1'b0;
        p0_rdata_d    = p0_rdata_q;
        p1_rdata_d    = p1_rdata_q;
        refresh_grant = 1'b0;
        grant_en      = 1'b0;
        grant_sel     = 1'b0;
        complete      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q >= PEND_URGENT) begin
                    refresh_grant = 1'b1;
                end else if (p0_elig && p1_elig) begin
                    grant_en  = 1'b1;
                    grant_sel = ~last_grant_q;
                end else if (p0_elig) begin
                    grant_en  = 1'b1;
                    grant_sel = 1'b0;
                end else if (p1_elig) begin
                    grant_en  = 1'b1;
                    grant_sel = 1'b1;
                end else if (pend_q != '0) begin
                    refresh_grant = 1'b1;
                end

                if (refresh_grant) begin
                    state_d       = REFRESH;
                    ctl_refresh_d = 1'b1;
                end

                if (grant_en) begin
                    state_d      = ISSUE;
                    ctl_req_d    = 1'b1;
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    ctl_wr_d     = grant_sel ? bus.p1_wr    : bus.p0_wr;
                    ctl_addr_d   = grant_sel ? bus.p1_addr  : bus.p0_addr;
                    ctl_wdata_d  = grant_sel ? bus.p1_wdata : bus.p0_wdata;
                    ctl_be_d     = grant_sel ? bus.p1_be    : bus.p0_be;
                end
            end

            ISSUE: begin
                if (bus.ctl_ack) begin
                    ctl_req_d = 1'b0;
                    if (bus.ctl_done) begin
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (bus.ctl_done) begin
                    complete = 1'b1;
                end
            end

            REFRESH: begin
                if (bus.ctl_refresh_done) begin
                    ctl_refresh_d = 1'b0;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion returns ack (and read data) to the owning client only.
        if (complete) begin
            state_d = IDLE;
            if (owner_q) begin
                p1_ack_d = 1'b1;
                if (!ctl_wr_q) begin
                    p1_rdata_d = bus.ctl_rdata;
                end
            end else begin
                p0_ack_d = 1'b1;
                if (!ctl_wr_q) begin
                    p0_rdata_d = bus.ctl_rdata;
                end
            end
        end
    end

    // State and output registers; reset abandons any transaction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_RELOAD;
            pend_q        <= '0;
            ovf_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            ctl_req_q     <= 1'b0;
            ctl_wr_q      <= 1'b0;
            ctl_addr_q    <= '0;
            ctl_wdata_q   <= '0;
            ctl_be_q      <= '0;
            ctl_refresh_q <= 1'b0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            ovf_q         <= ovf_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            ctl_req_q     <= ctl_req_d;
            ctl_wr_q      <= ctl_wr_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_wdata_q   <= ctl_wdata_d;
            ctl_be_q      <= ctl_be_d;
            ctl_refresh_q <= ctl_refresh_d;
            p0_ack_q      <= p0_ack_d;
            p1_ack_q      <= p1_ack_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_rdata_q    <= p1_rdata_d;
        end
    end

    assign bus.ctl_req     = ctl_req_q;
    assign bus.ctl_wr      = ctl_wr_q;
    assign bus.ctl_addr    = ctl_addr_q;
    assign bus.ctl_wdata   = ctl_wdata_q;
    assign bus.ctl_be      = ctl_be_q;
    assign bus.ctl_refresh = ctl_refresh_q;
    assign bus.p0_ack      = p0_ack_q;
    assign bus.p1_ack      = p1_ack_q;
    assign bus.p0_rdata    = p0_rdata_q;
    assign bus.p1_rdata    = p1_rdata_q;
    assign busy             = (state_q != IDLE);
    assign refresh_overflow = ovf_q;

endmodule
